// File: rtl/ysyx_22050019_axi_arbiter.sv
// Shares one single-beat AXI slave port between the icache (M0, read-only) and the dcache (M1, read/write).
// One transaction at a time; writes win, and tied reads alternate round-robin.
module ysyx_22050019_axi_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_ar_valid_i,
  output logic                    m0_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]   m0_ar_addr_i,
  output logic                    m0_r_valid_o,
  input  logic                    m0_r_ready_i,
  output logic [1:0]              m0_r_resp_o,
  output logic [DATA_WIDTH-1:0]   m0_r_data_o,
  input  logic                    m1_ar_valid_i,
  output logic                    m1_ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]   m1_ar_addr_i,
  output logic                    m1_r_valid_o,
  input  logic                    m1_r_ready_i,
  output logic [1:0]              m1_r_resp_o,
  output logic [DATA_WIDTH-1:0]   m1_r_data_o,
  input  logic                    m1_aw_valid_i,
  output logic                    m1_aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]   m1_aw_addr_i,
  input  logic                    m1_w_valid_i,
  output logic                    m1_w_ready_o,
  input  logic [DATA_WIDTH-1:0]   m1_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] m1_w_strb_i,
  output logic                    m1_b_valid_o,
  input  logic                    m1_b_ready_i,
  output logic [1:0]              m1_b_resp_o,
  output logic                    s_ar_valid_o,
  input  logic                    s_ar_ready_i,
  output logic [ADDR_WIDTH-1:0]   s_ar_addr_o,
  input  logic                    s_r_valid_i,
  output logic                    s_r_ready_o,
  input  logic [1:0]              s_r_resp_i,
  input  logic [DATA_WIDTH-1:0]   s_r_data_i,
  output logic                    s_aw_valid_o,
  input  logic                    s_aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   s_aw_addr_o,
  output logic                    s_w_valid_o,
  input  logic                    s_w_ready_i,
  output logic [DATA_WIDTH-1:0]   s_w_data_o,
  output logic [DATA_WIDTH/8-1:0] s_w_strb_o,
  input  logic                    s_b_valid_i,
  output logic                    s_b_ready_o,
  input  logic [1:0]              s_b_resp_i
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_q, last_d;

  // last resets to 1 so that M0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    m0_ar_ready_o = 1'b0;
    m0_r_valid_o  = 1'b0;
    m0_r_resp_o   = '0;
    m0_r_data_o   = '0;
    m1_ar_ready_o = 1'b0;
    m1_r_valid_o  = 1'b0;
    m1_r_resp_o   = '0;
    m1_r_data_o   = '0;
    m1_aw_ready_o = 1'b0;
    m1_w_ready_o  = 1'b0;
    m1_b_valid_o  = 1'b0;
    m1_b_resp_o   = '0;
    s_ar_valid_o  = 1'b0;
    s_ar_addr_o   = '0;
    s_r_ready_o   = 1'b0;
    s_aw_valid_o  = 1'b0;
    s_aw_addr_o   = '0;
    s_w_valid_o   = 1'b0;
    s_w_data_o    = '0;
    s_w_strb_o    = '0;
    s_b_ready_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m1_aw_valid_i) begin
          state_d = WR_AW;
        end else if (m0_ar_valid_i && m1_ar_valid_i) begin
          state_d = RD_AR;
          gnt_d   = ~last_q;
        end else if (m0_ar_valid_i) begin
          state_d = RD_AR;
          gnt_d   = 1'b0;
        end else if (m1_ar_valid_i) begin
          state_d = RD_AR;
          gnt_d   = 1'b1;
        end
      end
      RD_AR: begin
        s_ar_valid_o = gnt_q ? m1_ar_valid_i : m0_ar_valid_i;
        s_ar_addr_o  = gnt_q ? m1_ar_addr_i : m0_ar_addr_i;
        if (gnt_q) m1_ar_ready_o = s_ar_ready_i;
        else       m0_ar_ready_o = s_ar_ready_i;
        if (s_ar_valid_o && s_ar_ready_i) state_d = RD_R;
      end
      RD_R: begin
        if (gnt_q) begin
          m1_r_valid_o = s_r_valid_i;
          m1_r_data_o  = s_r_data_i;
          m1_r_resp_o  = s_r_resp_i;
          s_r_ready_o  = m1_r_ready_i;
        end else begin
          m0_r_valid_o = s_r_valid_i;
          m0_r_data_o  = s_r_data_i;
          m0_r_resp_o  = s_r_resp_i;
          s_r_ready_o  = m0_r_ready_i;
        end
        if (s_r_valid_i && s_r_ready_o) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      WR_AW: begin
        s_aw_valid_o  = m1_aw_valid_i;
        s_aw_addr_o   = m1_aw_addr_i;
        m1_aw_ready_o = s_aw_ready_i;
        if (m1_aw_valid_i && s_aw_ready_i) state_d = WR_W;
      end
      WR_W: begin
        s_w_valid_o  = m1_w_valid_i;
        s_w_data_o   = m1_w_data_i;
        s_w_strb_o   = m1_w_strb_i;
        m1_w_ready_o = s_w_ready_i;
        if (m1_w_valid_i && s_w_ready_i) state_d = WR_B;
      end
      WR_B: begin
        m1_b_valid_o = s_b_valid_i;
        m1_b_resp_o  = s_b_resp_i;
        s_b_ready_o  = m1_b_ready_i;
        if (s_b_valid_i && m1_b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ysyx_22050019_axi_arbiter.md
# ysyx_22050019_axi_arbiter

Shares the single AXI memory port between the instruction cache and the data cache. The icache has one read-only master port (M0). The dcache has one read/write master port (M1). The block grants exactly one single-beat transaction at a time and steers each channel's valid/ready/payload between the granted master and the downstream slave (memory or DPI bridge). It sits between the two caches' cache_* ports and the memory interface.

## Interface
- ADDR_WIDTH, 32, address width on every AR/AW channel
- DATA_WIDTH, 64, data width on R/W channels; strobe width DATA_WIDTH/8
- Reset is `rst`: synchronous, active-high. Clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_ar_valid_i  in  1  icache read request
- m0_ar_ready_o  out  1  icache AR accept
- m0_ar_addr_i  in  ADDR_WIDTH  icache read address
- m0_r_valid_o  out  1  icache read data valid
- m0_r_ready_i  in  1  icache read data ready
- m0_r_resp_o  out  2  icache read response
- m0_r_data_o  out  DATA_WIDTH  icache read data
- m1_ar_valid_i / m1_ar_ready_o / m1_ar_addr_i / m1_r_valid_o / m1_r_ready_i / m1_r_resp_o / m1_r_data_o  same as m0, for the dcache
- m1_aw_valid_i  in  1  dcache write address valid
- m1_aw_ready_o  out  1  dcache write address ready
- m1_aw_addr_i  in  ADDR_WIDTH  dcache write address
- m1_w_valid_i  in  1  dcache write data valid
- m1_w_ready_o  out  1  dcache write data ready
- m1_w_data_i  in  DATA_WIDTH  dcache write data
- m1_w_strb_i  in  DATA_WIDTH/8  dcache write strobe
- m1_b_valid_o  out  1  dcache write response valid
- m1_b_ready_i  in  1  dcache write response ready
- m1_b_resp_o  out  2  dcache write response
- s_ar_valid_o, s_ar_ready_i, s_ar_addr_o, s_r_valid_i, s_r_ready_o, s_r_resp_i, s_r_data_i, s_aw_valid_o, s_aw_ready_i, s_aw_addr_o, s_w_valid_o, s_w_ready_i, s_w_data_o, s_w_strb_o, s_b_valid_i, s_b_ready_o, s_b_resp_i  slave-side mirror, same widths

## Operation
- **State register** (one-hot or encoded): IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B.
- **Registered state:** `gnt` (0 = M0, 1 = M1, holds the granted read master) and `last` (last read grantee).
- **Transitions out of IDLE**, evaluated on request inputs:
  - m1_aw_valid_i=1 → WR_AW. Writes have top priority.
  - Else if exactly one of m0/m1_ar_valid_i is high → RD_AR, gnt = that master.
  - Else if both are high → RD_AR, gnt = ~last (round-robin).
  - Else stay in IDLE.
- **Read sequence:**
  - RD_AR → RD_R on s_ar_valid_o & s_ar_ready_i.
  - RD_R → IDLE on s_r_valid_i & s_r_ready_o; `last` ← gnt on this handshake.
- **Write sequence:**
  - WR_AW → WR_W on the AW handshake.
  - WR_W → WR_B on the W handshake.
  - WR_B → IDLE on the B handshake.
- **Steering** is purely combinational from state and gnt; no payload registers.
  - RD_AR: s_ar_valid_o = m[gnt]_ar_valid_i, s_ar_addr_o = m[gnt]_ar_addr_i, m[gnt]_ar_ready_o = s_ar_ready_i.
  - RD_R: m[gnt]_r_valid_o = s_r_valid_i, m[gnt]_r_data_o = s_r_data_i, m[gnt]_r_resp_o = s_r_resp_i, s_r_ready_o = m[gnt]_r_ready_i.
  - WR_*: the corresponding M1 channel connects straight through to the slave.
- **All other outputs are 0**, in every state where they are not steered. This includes:
  - the ungranted master's ready, valid, data and resp;
  - every upstream ready while in IDLE.
- Single-beat transactions only; no ID or burst fields. At most one outstanding transaction in total.
- A master that deasserts valid before its handshake leaves the FSM waiting in the same state. No timeout.

## Timing
- **Reset values:** state = IDLE, gnt = 0, last = 1, so M0 wins the first tie. Every output is 0 after reset. Reset asserted mid-transaction aborts it: the next cycle is IDLE with all outputs 0.
- **Grant latency:** a request first high in cycle N is granted at the clock edge ending N. Its earliest AR/AW handshake is in cycle N+1.
- **Per-transaction cost:**
  - Read with zero-wait slave: AR handshake at N+1, R handshake at N+2, back in IDLE at N+3. Minimum 3 cycles.
  - Write with zero-wait slave: 4 cycles minimum.
- **Ready timing:** ready to a master is combinational from the slave ready. No extra bubble beyond the IDLE arbitration cycle.
- **Simultaneous events:**
  - AW and both ARs in the same IDLE cycle: the write is served first. The ARs remain pending and are arbitrated again in the next IDLE.
  - A request that arrives while another transaction is in progress is held off by ready=0 until IDLE.

## Test plan
- **Single icache read:** m0_ar_valid_i=1, addr 0x8000_0000, slave returns data 0x1122334455667788 with zero wait.
  - s_ar_addr_o = 0x8000_0000 one cycle after the request.
  - m0_r_data_o carries the value with m0_r_valid_o=1.
  - M1 outputs stay 0 throughout.
- **Tie after reset:** both ARs high on the first cycle.
  - M0 is granted first, then M1.
  - If both are re-asserted together, M0 wins the next tie (round-robin).
- **Write priority:** m1_aw_valid_i and m0_ar_valid_i high together.
  - The WR_AW/W/B sequence completes first, with strb 0xFF passed through.
  - The M0 read completes afterwards.
- **Slave backpressure:** s_ar_ready_i held 0 for 5 cycles.
  - The arbiter stays in RD_AR.
  - m[gnt]_ar_ready_o stays 0.
  - The other master's requests are not accepted.
- **Reset mid-write:** rst pulsed in WR_W.
  - All outputs are 0 the next cycle.
  - A subsequent M0 read completes normally.
- **Master R backpressure:** m1_r_ready_i held 0 for 3 cycles.
  - s_r_ready_o = 0 during those cycles.
  - IDLE is reached only after m1_r_ready_i rises.
